key_event_queue: RTL and testbench
==================================

Name: key_event_queue

Overview:
- Consumer end of the debounced key-press path.
- Collects one-cycle press pulses from NUM_KEYS debouncer instances and encodes each pulse as a key code.
- Buffers the codes in order in a small FIFO.
- The Tetris game FSM pops one event at a time, typically once per frame tick. No press is lost between frames, and simultaneous presses are serialized deterministically.

Parameters:
- NUM_KEYS, 4: number of pulse inputs. Fixed key map is 0=left, 1=right, 2=rotate, 3=drop.
- CODE_W, 2: event code width. Must satisfy 2**CODE_W >= NUM_KEYS.
- DEPTH, 8: FIFO entries. Must be a power of two and at least 2.
- CNT_W, 4: occupancy counter width, equal to clog2(DEPTH+1).

Ports:
- clk  in  1  system clock (VGA pixel clock domain).
- rst  in  1  synchronous active-high reset.
- key_pulse  in  NUM_KEYS  one-cycle press pulses, bit i = key i.
- pop  in  1  consumer acknowledges the head event. Ignored when event_valid=0.
- clr_overflow  in  1  clears the sticky overflow flag.
- event_valid  out  1  FIFO not empty.
- event_code  out  CODE_W  head event code. Show-ahead: valid whenever event_valid=1.
- count  out  CNT_W  current FIFO occupancy, 0..DEPTH.
- overflow  out  1  sticky flag: at least one press was dropped.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous, active-high, and sampled at posedge clk only.
  - Reset values: event_valid=0, event_code=0, count=0, overflow=0, pending mask=0, FIFO pointers=0.
  - Reset mid-operation discards all queued and pending events. rst has priority over every other input in that cycle.
- Stage 1, pending mask (NUM_KEYS bits):
  - Each edge: pending_next = (pending & ~grant) | key_pulse.
  - A pulse on bit i while pending[i]=1 and bit i is not granted that cycle is a dropped press: set overflow, pending[i] stays 1.
  - A pulse on bit i in the same cycle it is granted re-sets pending[i]. Nothing is lost.
- Stage 2, grant/push:
  - grant = lowest-index set bit of pending, only when push is allowed.
  - Push is allowed when count<DEPTH, or when count==DEPTH and pop is accepted in the same cycle.
  - The pushed code equals the binary index of the granted bit.
  - At most one push per cycle.
- Latency:
  - A pulse sampled at edge N is in pending after edge N.
  - If the FIFO has room and no lower-index bit is pending, the event is written at edge N+1. event_valid and event_code reflect it after edge N+1.
- FIFO behaviour:
  - Pop accepted when pop=1 and count>0. The head advances at the edge; the next head is visible the following cycle.
  - Simultaneous push and pop: count unchanged, order preserved.
  - Pop on empty: no effect. Count never underflows.
  - FIFO full: pending bits are held, not dropped. Overflow arises only from the pending-collision rule above.
  - Pointers wrap modulo DEPTH.
- Output timing: event_code and count are registered or derived directly from the storage/pointer registers. No combinational path from key_pulse to any output.
- Overflow flag:
  - clr_overflow clears overflow at the edge.
  - If clr_overflow and a new drop occur in the same cycle, overflow ends at 1.

Decomposition:
- Shared package or header (key_defs):
  - KEY_LEFT=0, KEY_RIGHT=1, KEY_ROTATE=2, KEY_DROP=3.
  - NUM_KEYS and CODE_W defaults.
- Sub-module sync_fifo:
  - Parameterized by WIDTH and DEPTH.
  - Ports: clk, rst, wr_en, wr_data, rd_en, rd_data, count, full, empty.
  - Show-ahead read. Supports simultaneous read and write when full.
  - Reusable elsewhere, for example a score/line event queue.
- Top level holds only the pending mask, the priority grant and overflow logic.

Test Plan:
- Reset, then a single pulse on key_pulse=4'b0100 at edge 1 -> event_valid=1 and event_code=2 after edge 2; pop -> event_valid=0, count=0.
- Simultaneous pulse 4'b1011 in one cycle -> codes 0, 1, 3 appear in that order, one pushed per cycle; count reaches 3; overflow=0.
- Eight separate pulses on key 3 with no pop -> count=8. A further pulse on key 0 stays pending. Pop once -> code 0 is pushed into the freed slot; count stays 8; overflow=0.
- While FIFO full and pending[1]=1, a second pulse on key 1 -> overflow=1. clr_overflow for one cycle -> overflow=0.
- FIFO full, pop held high while pulses arrive every cycle on rotating keys -> count stays 8 and output order matches input order. Pop with count=0 -> count stays 0.
- rst asserted while count=5 and pending=4'b0110 -> after that edge, count=0, event_valid=0, overflow=0. No stale event appears afterwards.

Source files
------------

// File: rtl/key_event_queue_pkg.sv
// Shared key map and default sizing for the key event path.
package key_event_queue_pkg;

    localparam int NUM_KEYS = 4;
    localparam int CODE_W   = 2;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 4;

    localparam int KEY_LEFT   = 0;
    localparam int KEY_RIGHT  = 1;
    localparam int KEY_ROTATE = 2;
    localparam int KEY_DROP   = 3;

    typedef logic [CODE_W-1:0] code_t;

endpackage

// File: rtl/key_event_queue_if.sv
// Consumer-facing event port: show-ahead head, pop and overflow status.
interface key_event_queue_if
    import key_event_queue_pkg::*;
#(
    parameter int CODE_W = key_event_queue_pkg::CODE_W,
    parameter int CNT_W  = key_event_queue_pkg::CNT_W
) ();

    logic              event_valid;
    logic [CODE_W-1:0] event_code;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              pop;
    logic              clr_overflow;

    modport master (
        output event_valid, event_code, count, overflow,
        input  pop, clr_overflow
    );

    modport slave (
        input  event_valid, event_code, count, overflow,
        output pop, clr_overflow
    );

endinterface

// File: rtl/key_event_queue_sync_fifo.sv
// Show-ahead synchronous FIFO; accepts a write when full if a read retires.
module sync_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             rd_ok;
    logic             wr_ok;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    // Head is forced to zero when empty so no stale entry ever shows.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (rd_ok)
                rd_ptr <= rd_ptr + AW'(1);
            unique case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Latches key press pulses, serializes them lowest-index first into a FIFO.
module key_event_queue
    import key_event_queue_pkg::*;
#(
    parameter int NUM_KEYS = key_event_queue_pkg::NUM_KEYS,
    parameter int CODE_W   = key_event_queue_pkg::CODE_W,
    parameter int DEPTH    = key_event_queue_pkg::DEPTH,
    parameter int CNT_W    = key_event_queue_pkg::CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_pulse,
    key_event_queue_if.master   ev
);

    logic [NUM_KEYS-1:0] pending;
    logic [NUM_KEYS-1:0] grant;
    logic [CODE_W-1:0]   grant_code;
    logic                full;
    logic                empty;
    logic                pop_acc;
    logic                push_ok;
    logic                drop;
    logic                overflow_q;

    assign pop_acc = ev.pop & ~empty;
    assign push_ok = ~full | pop_acc;
    assign grant   = push_ok ? (pending & (~pending + 1'b1)) : '0;
    assign drop    = |(key_pulse & pending & ~grant);

    always_comb begin
        grant_code = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--)
            if (pending[i])
                grant_code = CODE_W'(i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            overflow_q <= 1'b0;
        end else begin
            pending <= (pending & ~grant) | key_pulse;
            // A drop in the same cycle as a clear must stay visible.
            if (drop)
                overflow_q <= 1'b1;
            else if (ev.clr_overflow)
                overflow_q <= 1'b0;
        end
    end

    sync_fifo #(
        .WIDTH (CODE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (|grant),
        .wr_data (grant_code),
        .rd_en   (ev.pop),
        .rd_data (ev.event_code),
        .count   (ev.count),
        .full    (full),
        .empty   (empty)
    );

    assign ev.event_valid = ~empty;
    assign ev.overflow    = overflow_q;

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench with an expected-code scoreboard for key_event_queue.
module tb_key_event_queue;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] key_pulse = '0;
    int         checks = 0;
    int         errors = 0;
    int         exp_q[$];

    key_event_queue_if #(.CODE_W(2), .CNT_W(4)) ev ();

    key_event_queue dut (
        .clk       (clk),
        .rst       (rst),
        .key_pulse (key_pulse),
        .ev        (ev)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic pulse(int k);
        key_pulse = 4'(1 << k);
        tick();
        key_pulse = '0;
    endtask

    task automatic check_head(string tag);
        int e;
        checks++;
        assert (exp_q.size() > 0)
        else begin
            errors++;
            $error("FAIL %s: observed output expected none", tag);
        end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 0;
        check({tag, "_valid"}, 32'(ev.event_valid), 32'd1);
        check({tag, "_code"}, 32'(ev.event_code), 32'(e));
    endtask

    task automatic pop_one(string tag);
        check_head(tag);
        ev.pop = 1'b1;
        tick();
        ev.pop = 1'b0;
    endtask

    initial begin
        ev.pop = 1'b0;
        ev.clr_overflow = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_valid", 32'(ev.event_valid), 32'd0);
        check("rst_code", 32'(ev.event_code), 32'd0);
        check("rst_count", 32'(ev.count), 32'd0);
        check("rst_ovf", 32'(ev.overflow), 32'd0);

        // single press, two-edge latency
        key_pulse = 4'b0100;
        tick();
        key_pulse = '0;
        check("lat_e1_valid", 32'(ev.event_valid), 32'd0);
        exp_q.push_back(2);
        tick();
        check("lat_e2_count", 32'(ev.count), 32'd1);
        pop_one("single");
        check("single_empty", 32'(ev.event_valid), 32'd0);
        check("single_count", 32'(ev.count), 32'd0);

        // simultaneous presses serialized lowest first
        key_pulse = 4'b1011;
        tick();
        key_pulse = '0;
        exp_q.push_back(0);
        exp_q.push_back(1);
        exp_q.push_back(3);
        tick();
        check("multi_c1", 32'(ev.count), 32'd1);
        tick();
        tick();
        check("multi_count", 32'(ev.count), 32'd3);
        check("multi_ovf", 32'(ev.overflow), 32'd0);
        for (int i = 0; i < 3; i++)
            pop_one("multi");
        check("multi_drained", 32'(ev.count), 32'd0);

        // fill with drops, then hold a left press
        for (int i = 0; i < 8; i++) begin
            pulse(3);
            exp_q.push_back(3);
        end
        tick();
        check("full_count", 32'(ev.count), 32'd8);
        pulse(0);
        tick();
        check("full_hold", 32'(ev.count), 32'd8);
        exp_q.push_back(0);
        pop_one("full_pop");
        check("refill_count", 32'(ev.count), 32'd8);
        check("refill_ovf", 32'(ev.overflow), 32'd0);

        // collision on a held pending bit
        pulse(1);
        check("pend1_ovf", 32'(ev.overflow), 32'd0);
        pulse(1);
        check("coll_ovf", 32'(ev.overflow), 32'd1);
        check("coll_count", 32'(ev.count), 32'd8);
        exp_q.push_back(1);
        ev.clr_overflow = 1'b1;
        tick();
        ev.clr_overflow = 1'b0;
        check("clr_ovf", 32'(ev.overflow), 32'd0);

        // streaming: full, pop every cycle, rotating keys
        for (int i = 0; i < 8; i++) begin
            check_head("stream");
            key_pulse = 4'(1 << (i % 4));
            exp_q.push_back(i % 4);
            ev.pop = 1'b1;
            tick();
            check("stream_count", 32'(ev.count), 32'd8);
        end
        key_pulse = '0;
        ev.pop = 1'b0;
        tick();
        check("stream_ovf", 32'(ev.overflow), 32'd0);
        for (int i = 0; i < 9; i++)
            pop_one("drain");
        tick();
        check("drain_count", 32'(ev.count), 32'd0);
        check("drain_left", 32'(exp_q.size()), 32'd0);
        ev.pop = 1'b1;
        tick();
        ev.pop = 1'b0;
        check("empty_pop_count", 32'(ev.count), 32'd0);
        check("empty_pop_valid", 32'(ev.event_valid), 32'd0);

        // reset mid-operation
        for (int i = 0; i < 5; i++)
            pulse(2);
        tick();
        check("pre_rst_count", 32'(ev.count), 32'd5);
        key_pulse = 4'b0110;
        tick();
        key_pulse = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.delete();
        check("mid_rst_count", 32'(ev.count), 32'd0);
        check("mid_rst_valid", 32'(ev.event_valid), 32'd0);
        check("mid_rst_ovf", 32'(ev.overflow), 32'd0);
        for (int i = 0; i < 4; i++)
            tick();
        check("post_rst_valid", 32'(ev.event_valid), 32'd0);
        check("post_rst_count", 32'(ev.count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
